icache_refill_responder: RTL and testbench

ICACHE_REFILL_RESPONDER -- requirements
Module: icache_refill_responder

---
 rtl/icache_refill_responder_pkg.sv | 13 +
 rtl/icache_refill_responder.sv | 143 ++++++++++++++
 tb/tb_icache_refill_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_responder_pkg.sv
// Shared defaults and FSM state encoding for the icache refill responder.
package icache_refill_responder_pkg;

    localparam int unsigned DEF_BLOCK_WIDTH = 128;
    localparam int unsigned DEF_MEM_WIDTH   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RESPOND
    } state_e;

endpackage

// File: rtl/icache_refill_responder.sv
// One-line refill buffer between the icache and a pipelined memory port:
// serves hits from the buffer, otherwise fetches the line beat by beat and responds.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | wait for a request; a buffer hit is answered combinationally
//   ST_FETCH   | issue beat requests and collect in-order beat responses
//   ST_RESPOND | one-cycle ready_o pulse with the assembled line
module icache_refill_responder
    import icache_refill_responder_pkg::*;
#(
    parameter int unsigned BLOCK_WIDTH = DEF_BLOCK_WIDTH,
    parameter int unsigned MEM_WIDTH   = DEF_MEM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    input  logic [31:0]            address_i,
    output logic                   ready_o,
    output logic [BLOCK_WIDTH-1:0] data_o,
    input  logic                   flush_i,
    output logic                   mem_req_o,
    output logic [31:0]            mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [MEM_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned BEATS = BLOCK_WIDTH / MEM_WIDTH;
    localparam int unsigned CNT_W = $clog2(BEATS) + 1;
    localparam int unsigned OFFS  = $clog2(BLOCK_WIDTH / 8);
    localparam int unsigned TAG_W = 32 - OFFS;

    localparam logic [CNT_W-1:0] BEATS_C    = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [31:0]      BEAT_BYTES = 32'(MEM_WIDTH / 8);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]       rsp_cnt_q, rsp_cnt_d;
    logic                   buf_valid_q, buf_valid_d;
    logic                   poison_q, poison_d;
    logic [TAG_W-1:0]       line_tag_q, line_tag_d;
    logic [TAG_W-1:0]       base_q, base_d;
    logic [BLOCK_WIDTH-1:0] buf_q, buf_d;
    logic                   hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            buf_valid_q <= 1'b0;
            poison_q    <= 1'b0;
            line_tag_q  <= '0;
            base_q      <= '0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_cnt_q   <= req_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            buf_valid_q <= buf_valid_d;
            poison_q    <= poison_d;
            line_tag_q  <= line_tag_d;
            base_q      <= base_d;
            buf_q       <= buf_d;
        end
    end

    assign data_o = buf_q;
    assign hit    = buf_valid_q && (address_i[31:OFFS] == line_tag_q);

    always_comb begin
        state_d     = state_q;
        req_cnt_d   = req_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        buf_valid_d = buf_valid_q;
        poison_d    = poison_q;
        line_tag_d  = line_tag_q;
        base_d      = base_q;
        buf_d       = buf_q;
        ready_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;

        // A hit in the same cycle still reads the old buf_valid_q, so it is served.
        if (flush_i) begin
            buf_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (hit) begin
                        ready_o = 1'b1;
                    end else begin
                        base_d      = address_i[31:OFFS];
                        req_cnt_d   = '0;
                        rsp_cnt_d   = '0;
                        buf_valid_d = 1'b0;
                        state_d     = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (flush_i) begin
                    poison_d = 1'b1;
                end
                if (req_cnt_q < BEATS_C) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = {base_q, {OFFS{1'b0}}} + 32'(req_cnt_q) * BEAT_BYTES;
                    if (mem_gnt_i) begin
                        req_cnt_d = req_cnt_q + ONE_C;
                    end
                end
                // Responses with nothing outstanding are strays and are dropped.
                if (mem_rvalid_i && (rsp_cnt_q != req_cnt_q)) begin
                    for (int b = 0; b < int'(BEATS); b++) begin
                        if (rsp_cnt_q == CNT_W'(b)) begin
                            buf_d[b*MEM_WIDTH +: MEM_WIDTH] = mem_rdata_i;
                        end
                    end
                    rsp_cnt_d = rsp_cnt_q + ONE_C;
                    if (rsp_cnt_q == LAST_C) begin
                        line_tag_d  = base_q;
                        buf_valid_d = !(poison_q || flush_i);
                        state_d     = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                ready_o  = 1'b1;
                poison_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_refill_responder.sv
// Directed bench for icache_refill_responder with a small pipelined memory model
// whose grant stall and response gap are adjustable per test.
module tb_icache_refill_responder;

    localparam logic [127:0] EXP_1230 = 128'hC0DE123C_C0DE1238_C0DE1234_C0DE1230;
    localparam logic [127:0] EXP_4010 = 128'hC0DE401C_C0DE4018_C0DE4014_C0DE4010;
    localparam logic [127:0] EXP_2000 = 128'hC0DE200C_C0DE2008_C0DE2004_C0DE2000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_i = 1'b0;
    logic [31:0]  address_i = '0;
    logic         ready_o;
    logic [127:0] data_o;
    logic         flush_i = 1'b0;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_gnt_i = 1'b0;
    logic         mem_rvalid_i = 1'b0;
    logic [31:0]  mem_rdata_i = '0;

    int n_checks = 0;
    int n_errors = 0;

    int gnt_stall = 0;
    int rsp_gap = 0;
    int stray_reqs = 0;
    int stray_done = 0;
    int stall_cnt = 0;
    int gap_cnt = 0;
    int gnt_cnt = 0;
    logic [31:0] pend_q[$];
    logic [31:0] addr_log[$];

    icache_refill_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .address_i    (address_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory: drives its inputs at the falling edge; mem_req_o/mem_addr_o are stable there.
    always @(negedge clk) begin
        if (stray_done < stray_reqs) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hDEAD_BEEF;
            stray_done++;
        end else if (pend_q.size() > 0 && gap_cnt == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(pend_q.pop_front());
            gap_cnt      = rsp_gap;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (gap_cnt > 0) gap_cnt--;
        end
        if (mem_req_o) begin
            if (stall_cnt == 0) begin
                mem_gnt_i = 1'b1;
                pend_q.push_back(mem_addr_o);
                addr_log.push_back(mem_addr_o);
                gnt_cnt++;
                stall_cnt = gnt_stall;
            end else begin
                mem_gnt_i = 1'b0;
                stall_cnt--;
            end
        end else begin
            mem_gnt_i = (gnt_stall == 0);
            stall_cnt = gnt_stall;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_fill(input string tag, input logic [31:0] addr, input logic [31:0] exp_base,
                            input logic [127:0] exp_data, input int flush_at);
        int log0, g0, n_rdy;
        logic [127:0] rdata;
        logic [31:0]  got_addr;
        log0  = addr_log.size();
        g0    = gnt_cnt;
        n_rdy = 0;
        rdata = '0;
        tick();
        valid_i   = 1'b1;
        address_i = addr;
        #1;
        check_val({tag, " miss no ready"}, ready_o, 1'b0);
        for (int c = 0; c < 200 && n_rdy == 0; c++) begin
            tick();
            valid_i = 1'b0;
            flush_i = (c == flush_at);
            #1;
            if (ready_o) begin
                n_rdy++;
                rdata = data_o;
            end
        end
        flush_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (ready_o) n_rdy++;
        end
        check_val({tag, " ready pulses"}, n_rdy, 1);
        check_val({tag, " data"}, rdata, exp_data);
        check_val({tag, " grants"}, gnt_cnt - g0, 4);
        for (int i = 0; i < 4; i++) begin
            got_addr = (addr_log.size() > log0 + i) ? addr_log[log0 + i] : 32'hFFFF_FFFF;
            check_val($sformatf("%s beat%0d addr", tag, i), got_addr, exp_base + 32'(4 * i));
        end
    endtask

    task automatic do_hit(input string tag, input logic [31:0] addr, input logic flush,
                          input logic [127:0] exp_data);
        tick();
        valid_i   = 1'b1;
        address_i = addr;
        flush_i   = flush;
        #1;
        check_val({tag, " ready"}, ready_o, 1'b1);
        check_val({tag, " data"}, data_o, exp_data);
        check_val({tag, " no mem_req"}, mem_req_o, 1'b0);
        tick();
        valid_i = 1'b0;
        flush_i = 1'b0;
        #1;
        check_val({tag, " single pulse"}, ready_o, 1'b0);
        check_val({tag, " stays idle"}, mem_req_o, 1'b0);
    endtask

    initial begin
        int g0;
        repeat (3) tick();
        check_val("reset ready_o", ready_o, 1'b0);
        check_val("reset mem_req_o", mem_req_o, 1'b0);
        check_val("reset mem_addr_o", mem_addr_o, 32'h0);
        check_val("reset data_o", data_o, 128'h0);
        rst_n = 1'b1;

        run_fill("fill1238", 32'h0000_1238, 32'h0000_1230, EXP_1230, -1);
        do_hit("hit123C", 32'h0000_123C, 1'b0, EXP_1230);

        stray_reqs++;
        repeat (3) tick();
        check_val("stray idle data", data_o, EXP_1230);
        do_hit("hit after stray", 32'h0000_1230, 1'b0, EXP_1230);

        gnt_stall = 3;
        rsp_gap   = 2;
        run_fill("stall4014", 32'h0000_4014, 32'h0000_4010, EXP_4010, -1);
        gnt_stall = 0;
        rsp_gap   = 0;

        run_fill("flush2000", 32'h0000_2000, 32'h0000_2000, EXP_2000, 2);
        run_fill("refetch2004", 32'h0000_2004, 32'h0000_2000, EXP_2000, -1);

        do_hit("hit with flush", 32'h0000_2008, 1'b1, EXP_2000);
        run_fill("miss after flush", 32'h0000_200C, 32'h0000_2000, EXP_2000, -1);

        // Reset after two beats granted, leaving one response still in flight.
        rsp_gap = 4;
        g0 = gnt_cnt;
        tick();
        valid_i   = 1'b1;
        address_i = 32'h0000_3000;
        tick();
        valid_i = 1'b0;
        for (int c = 0; c < 50 && (gnt_cnt - g0) < 2; c++) tick();
        check_val("midfetch grants", gnt_cnt - g0, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midfetch rst ready_o", ready_o, 1'b0);
        check_val("midfetch rst mem_req_o", mem_req_o, 1'b0);
        check_val("midfetch rst mem_addr_o", mem_addr_o, 32'h0);
        check_val("midfetch rst data_o", data_o, 128'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 30 && pend_q.size() > 0; c++) tick();
        repeat (3) tick();
        check_val("stray drained", pend_q.size(), 0);
        check_val("stray after rst data_o", data_o, 128'h0);
        check_val("stray after rst mem_req_o", mem_req_o, 1'b0);
        rsp_gap = 0;
        run_fill("after reset", 32'h0000_1238, 32'h0000_1230, EXP_1230, -1);
        do_hit("hit after reset", 32'h0000_1234, 1'b0, EXP_1230);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
